// File: rtl/ln05lpe_rd2r_256x1026_mem_ctrl.sv
// Controller for the 256x1026 1R/1W SRAM wrapper: zero-fill after reset, valid/ready write and
// read ports with same-cycle same-address write forwarding, and retention sleep/wake sequencing.
module ln05lpe_rd2r_256x1026_mem_ctrl #(
    parameter int unsigned DW       = 1026,
    parameter int unsigned AW       = 8,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned WAKE_CYC = 4,
    parameter logic [1:0]  MCSRD_V  = 2'b01,
    parameter logic [1:0]  MCSWR_V  = 2'b01,
    parameter logic [2:0]  ADME_V   = 3'b100
) (
    input  logic          CK,
    input  logic          RSTN,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    input  logic          sleep_req,
    output logic          sleep_ack,
    output logic          init_done,
    output logic          REN,
    output logic          WEN,
    output logic [AW-1:0] RA,
    output logic [AW-1:0] WA,
    output logic [DW-1:0] DI,
    input  logic [DW-1:0] DOUT,
    output logic [1:0]    MCSRD,
    output logic [1:0]    MCSWR,
    output logic [2:0]    ADME,
    output logic          RET
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_SLEEP,
        ST_WAKE
    } state_t;

    localparam int unsigned WCW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

    state_t          state_q, state_d;
    logic            init_en_q, init_en_d;
    logic [AW-1:0]   init_cnt_q, init_cnt_d;
    logic            init_done_q, init_done_d;
    logic [WCW-1:0]  wake_cnt_q, wake_cnt_d;
    logic            ret_q, ret_d;
    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0] fwd_hit_q, fwd_hit_d;
    logic [DW-1:0]   fwd_data_q [RD_LAT];
    logic [DW-1:0]   fwd_data_d [RD_LAT];
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic run_ok;
    logic wr_fire;
    logic rd_fire;
    logic collide;
    logic pipe_empty;

    assign run_ok     = (state_q == ST_RUN) && !sleep_req;
    assign wr_ready   = run_ok;
    assign rd_ready   = run_ok;
    assign wr_fire    = wr_valid && run_ok;
    assign rd_fire    = rd_valid && run_ok;
    assign collide    = wr_fire && rd_fire && (wr_addr == rd_addr);
    assign pipe_empty = !(|rd_vld_q) && !rsp_valid_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign init_done = init_done_q;
    assign sleep_ack = ret_q;
    assign RET       = ret_q;
    assign MCSRD     = MCSRD_V;
    assign MCSWR     = MCSWR_V;
    assign ADME      = ADME_V;

    // Macro pins follow the accepted request in the same cycle; the zero-fill owns the write port in INIT.
    always_comb begin
        REN = rd_fire;
        RA  = rd_fire ? rd_addr : '0;
        WEN = wr_fire;
        WA  = wr_fire ? wr_addr : '0;
        DI  = wr_fire ? wr_data : '0;
        if (state_q == ST_INIT && init_en_q) begin
            WEN = 1'b1;
            WA  = init_cnt_q;
            DI  = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_en_d   = 1'b1;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        wake_cnt_d  = wake_cnt_q;
        ret_d       = ret_q;
        case (state_q)
            ST_INIT: begin
                if (init_en_q) begin
                    init_cnt_d = init_cnt_q + 1'b1;
                    if (init_cnt_q == '1) begin
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (sleep_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_SLEEP;
                    ret_d   = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (!sleep_req) begin
                    state_d    = ST_WAKE;
                    ret_d      = 1'b0;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == WCW'(WAKE_CYC - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Read pipe: stage i holds the request fired i+1 cycles ago; the last stage meets valid DOUT.
    always_comb begin
        rd_vld_d     = rd_vld_q;
        fwd_hit_d    = fwd_hit_q;
        rd_vld_d[0]  = rd_fire;
        fwd_hit_d[0] = collide;
        fwd_data_d[0] = collide ? wr_data : fwd_data_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_d[i]   = rd_vld_q[i-1];
            fwd_hit_d[i]  = fwd_hit_q[i-1];
            fwd_data_d[i] = fwd_data_q[i-1];
        end
        rsp_valid_d = rd_vld_q[RD_LAT-1];
        rsp_data_d  = rsp_data_q;
        if (rd_vld_q[RD_LAT-1]) begin
            rsp_data_d = fwd_hit_q[RD_LAT-1] ? fwd_data_q[RD_LAT-1] : DOUT;
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_INIT;
            init_en_q   <= 1'b0;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            wake_cnt_q  <= '0;
            ret_q       <= 1'b0;
            rd_vld_q    <= '0;
            fwd_hit_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_en_q   <= init_en_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            wake_cnt_q  <= wake_cnt_d;
            ret_q       <= ret_d;
            rd_vld_q    <= rd_vld_d;
            fwd_hit_q   <= fwd_hit_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Forwarded data is qualified by fwd_hit_q, so it needs no reset.
    always_ff @(posedge CK) begin
        fwd_data_q <= fwd_data_d;
    end

endmodule

// File: tb/tb_ln05lpe_rd2r_256x1026_mem_ctrl.sv
// Scoreboard bench: SRAM behavioural model on the macro pins, reference memory for expected read data.
module tb_ln05lpe_rd2r_256x1026_mem_ctrl;

    localparam int DW       = 1026;
    localparam int AW       = 8;
    localparam int DEPTH    = 256;
    localparam int RD_LAT   = 1;
    localparam int WAKE_CYC = 4;

    logic          CK = 1'b0;
    logic          RSTN;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr_addr, rd_addr, RA, WA;
    logic [DW-1:0] wr_data, rsp_data, DI, DOUT;
    logic          rsp_valid, sleep_req, sleep_ack, init_done, REN, WEN, RET;
    logic [1:0]    MCSRD, MCSWR;
    logic [2:0]    ADME;

    ln05lpe_rd2r_256x1026_mem_ctrl dut (
        .CK(CK), .RSTN(RSTN),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sleep_req(sleep_req), .sleep_ack(sleep_ack), .init_done(init_done),
        .REN(REN), .WEN(WEN), .RA(RA), .WA(WA), .DI(DI), .DOUT(DOUT),
        .MCSRD(MCSRD), .MCSWR(MCSWR), .ADME(ADME), .RET(RET)
    );

    always #5 CK = ~CK;

    // SRAM model: read returns the pre-write contents, DOUT valid RD_LAT cycles after REN.
    logic [DW-1:0] sram [DEPTH];
    logic [DW-1:0] dout_pipe [RD_LAT];
    assign DOUT = dout_pipe[RD_LAT-1];
    always @(posedge CK) begin
        if (REN) dout_pipe[0] <= sram[RA];
        for (int i = 1; i < RD_LAT; i++) dout_pipe[i] <= dout_pipe[i-1];
        if (WEN) sram[WA] <= DI;
    end

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            exp_cyc_q [$];
    bit            run_mode = 0;

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d = '0;
        for (int i = 0; i < (DW + 31) / 32; i++) d = (d << 32) | DW'($urandom());
        return d;
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got[127:0]=%h exp[127:0]=%h (cycle %0d)", name, act[127:0], exp[127:0], cyc);
        end
    endtask

    // Monitor: every response is matched against the oldest outstanding expectation.
    always @(negedge CK) begin
        if (RSTN && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected got=1 exp=0 (cycle %0d)", cyc);
            end else begin
                logic [DW-1:0] d;
                int c;
                d = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check_data("rsp_data", rsp_data, d);
                check_val("rsp_latency_cycle", 64'(cyc), 64'(c));
            end
        end
    end

    task automatic check_outs_zero(input string tag);
        check_val({tag, "_wr_ready"}, wr_ready, 0);
        check_val({tag, "_rd_ready"}, rd_ready, 0);
        check_val({tag, "_rsp_valid"}, rsp_valid, 0);
        check_data({tag, "_rsp_data"}, rsp_data, '0);
        check_val({tag, "_sleep_ack"}, sleep_ack, 0);
        check_val({tag, "_init_done"}, init_done, 0);
        check_val({tag, "_REN"}, REN, 0);
        check_val({tag, "_WEN"}, WEN, 0);
        check_val({tag, "_RA"}, RA, 0);
        check_val({tag, "_WA"}, WA, 0);
        check_data({tag, "_DI"}, DI, '0);
        check_val({tag, "_RET"}, RET, 0);
    endtask

    // Releases reset and follows the zero-fill; stop_at >= 0 returns once that address was written.
    task automatic do_init(input int stop_at);
        int idx = 0;
        bit started = 0;
        @(negedge CK);
        RSTN = 1'b1;
        for (int t = 0; t < 400 && idx < DEPTH; t++) begin
            @(negedge CK);
            if (WEN) begin
                started = 1;
                check_val("init_WA", WA, 64'(idx));
                check_data("init_DI", DI, '0);
                check_val("init_done_early", init_done, 0);
                check_val("init_rsp_valid", rsp_valid, 0);
                idx++;
                if (idx == stop_at + 1) return;
            end else if (started) begin
                check_val("init_gap_WEN", WEN, 1);
            end
        end
        if (idx < DEPTH) begin
            checks++;
            failures++;
            $display("FAIL init_timeout got=%0d exp=%0d", idx, DEPTH);
        end
        @(negedge CK);
        check_val("init_done", init_done, 1);
        check_val("post_init_WEN", WEN, 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        run_mode = 1;
        @(posedge CK);
        #1;
    endtask

    // One clock of stimulus, entered and left at 1 time unit after the rising edge.
    task automatic drive_cycle(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic rv, input logic [AW-1:0] ra);
        logic wf, rf;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra;
        @(negedge CK);
        wf = wv && wr_ready;
        rf = rv && rd_ready;
        if (run_mode && !sleep_req) begin
            check_val("wr_ready_run", wr_ready, 1);
            check_val("rd_ready_run", rd_ready, 1);
        end
        check_val("WEN_fire", WEN, wf);
        check_val("REN_fire", REN, rf);
        if (wf) begin
            check_val("WA_fire", WA, wa);
            check_data("DI_fire", DI, wd);
        end
        if (rf) begin
            check_val("RA_fire", RA, ra);
            exp_q.push_back((wf && wa == ra) ? wd : ref_mem[ra]);
            exp_cyc_q.push_back(cyc + RD_LAT + 1);
        end
        if (wf) ref_mem[wa] = wd;
        @(posedge CK);
        #1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic drain_wait(input string name);
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge CK);
        check_val(name, 64'(exp_q.size()), 0);
        @(posedge CK);
        #1;
    endtask

    logic [DW-1:0] pat_a, pat_b;
    int            wake_cnt;

    initial begin
        RSTN = 1'b0; wr_valid = 0; rd_valid = 0; sleep_req = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        for (int i = 0; i < DEPTH; i++) sram[i] = rand_data();
        for (int i = 0; i < RD_LAT; i++) dout_pipe[i] = rand_data();
        #17;
        check_outs_zero("reset");
        check_val("MCSRD", MCSRD, 2'b01);
        check_val("MCSWR", MCSWR, 2'b01);
        check_val("ADME", ADME, 3'b100);

        // Zero-fill, then read back an untouched location
        do_init(-1);
        drive_cycle(0, '0, '0, 1, 8'h10);
        drain_wait("t1_drain");

        pat_a = {513{2'b01}};
        drive_cycle(1, 8'h3A, pat_a, 0, '0);
        drive_cycle(0, '0, '0, 1, 8'h3A);

        pat_b = rand_data();
        drive_cycle(1, 8'h55, pat_b, 0, '0);
        drive_cycle(1, 8'h55, ~pat_b, 1, 8'h55);
        drive_cycle(0, '0, '0, 1, 8'h55);
        drain_wait("t3_drain");

        // Random mixed traffic with frequent collisions
        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] wa, ra;
            wa = AW'($urandom_range(0, 255));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
            drive_cycle(1'($urandom_range(0, 1)), wa, rand_data(), 1'($urandom_range(0, 1)), ra);
        end
        drain_wait("rand_drain");

        for (int a = 0; a < DEPTH; a++) drive_cycle(0, '0, '0, 1, AW'(a));
        drain_wait("stream_drain");

        // Sleep with two reads in flight, then wake
        drive_cycle(0, '0, '0, 1, 8'h3A);
        drive_cycle(0, '0, '0, 1, 8'h55);
        sleep_req = 1'b1;
        run_mode = 0;
        @(negedge CK);
        check_val("sleep_wr_ready", wr_ready, 0);
        check_val("sleep_rd_ready", rd_ready, 0);
        for (int t = 0; t < 20 && !sleep_ack; t++) @(negedge CK);
        check_val("sleep_ack", sleep_ack, 1);
        check_val("sleep_RET", RET, 1);
        check_val("sleep_drained", 64'(exp_q.size()), 0);
        @(posedge CK);
        #1;
        drive_cycle(1, 8'h3A, rand_data(), 1, 8'h3A);
        sleep_req = 1'b0;
        @(posedge CK);
        #1;
        check_val("wake_RET", RET, 0);
        check_val("wake_sleep_ack", sleep_ack, 0);
        wake_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge CK);
            if (rd_ready) break;
            wake_cnt++;
        end
        check_val("wake_cycles", 64'(wake_cnt), 64'(WAKE_CYC));
        run_mode = 1;
        @(posedge CK);
        #1;
        drive_cycle(0, '0, '0, 1, 8'h3A);
        drive_cycle(0, '0, '0, 1, 8'h55);
        drive_cycle(0, '0, '0, 1, AW'($urandom_range(0, 255)));
        drain_wait("wake_drain");

        // Asynchronous reset in the middle of the zero-fill
        RSTN = 1'b0;
        run_mode = 0;
        exp_q.delete(); exp_cyc_q.delete();
        repeat (2) @(posedge CK);
        do_init(8'h80);
        #2;
        RSTN = 1'b0;
        #1;
        check_outs_zero("rst_mid_init");
        do_init(-1);

        // Asynchronous reset in the middle of a read stream
        for (int a = 0; a < 10; a++) drive_cycle(1, AW'(a + 1), rand_data(), 1, AW'(a));
        #2;
        RSTN = 1'b0;
        #1;
        check_outs_zero("rst_mid_stream");
        exp_q.delete(); exp_cyc_q.delete();
        run_mode = 0;
        repeat (3) @(posedge CK);
        do_init(-1);
        drive_cycle(0, '0, '0, 1, 8'h05);
        drive_cycle(0, '0, '0, 1, 8'h3A);
        drain_wait("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
